// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and helpers.
// Imported by the prefetch buffer and its ring storage.
package riscv_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        full;
  } fetchEntry_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ring_buffer.sv
// Circular prefetch storage with alloc/fill/read pointers.
// Entries are reserved at request time and filled in order.
module fetch_ring_buffer
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alloc_i,
  input  logic [31:0]   alloc_pc_i,
  input  logic          fill_i,
  input  logic [31:0]   fill_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetchEntry_t   head_o,
  output logic [PW-1:0] used_o,
  output logic [PW-1:0] outstanding_o
);

  localparam int IW = $clog2(DEPTH);

  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] read_q, read_d;
  fetchEntry_t   mem_q [DEPTH];
  fetchEntry_t   mem_d [DEPTH];

  // Next-state of pointers and entries; flush wins over everything.
  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    read_d  = read_q;
    mem_d   = mem_q;
    if (flush_i) begin
      alloc_d = '0;
      fill_d  = '0;
      read_d  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].full = 1'b0;
      end
    end else begin
      if (alloc_i) begin
        mem_d[alloc_q[IW-1:0]].pc = alloc_pc_i;
        alloc_d = alloc_q + PW'(1);
      end
      if (fill_i) begin
        mem_d[fill_q[IW-1:0]].instr = fill_data_i;
        mem_d[fill_q[IW-1:0]].full  = 1'b1;
        fill_d = fill_q + PW'(1);
      end
      if (pop_i) begin
        mem_d[read_q[IW-1:0]].full = 1'b0;
        read_d = read_q + PW'(1);
      end
    end
  end

  // Pointer and entry registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q <= '0;
      fill_q  <= '0;
      read_q  <= '0;
      mem_q   <= '{default: '0};
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      read_q  <= read_d;
      mem_q   <= mem_d;
    end
  end

  assign head_o        = mem_q[read_q[IW-1:0]];
  assign used_o        = alloc_q - read_q;
  assign outstanding_o = alloc_q - fill_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: owns fetch PC, issues imem requests,
// buffers responses and drops stale ones after redirect.
module instr_fetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_arstn,
  output logic        o_imemReqValid,
  input  logic        i_imemReqReady,
  output logic [31:0] o_imemReqAddr,
  input  logic        i_imemRspValid,
  input  logic [31:0] i_imemRspData,
  output logic        o_instrValid,
  input  logic        i_instrReady,
  output logic [31:0] o_instr,
  output logic [31:0] o_instrPc,
  input  logic        i_redirectValid,
  input  logic [31:0] i_redirectPc
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DEPTH + 1);

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [DW-1:0] dropCnt_q, dropCnt_d;
  logic [PW-1:0] used;
  logic [PW-1:0] outstanding;
  fetchEntry_t   head;
  logic          reqFire;
  logic          rspFill;
  logic          consume;

  assign o_imemReqValid = i_arstn && (used < PW'(DEPTH))
                          && !i_redirectValid;
  assign o_imemReqAddr  = fetchPc_q;
  assign reqFire        = o_imemReqValid && i_imemReqReady;
  assign rspFill        = i_imemRspValid && (dropCnt_q == '0)
                          && !i_redirectValid;
  assign consume        = head.full && i_instrReady
                          && !i_redirectValid;

  assign o_instrValid = head.full;
  assign o_instr      = head.instr;
  assign o_instrPc    = head.pc;

  fetch_ring_buffer #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i         (i_clk),
    .rst_ni        (i_arstn),
    .alloc_i       (reqFire),
    .alloc_pc_i    (fetchPc_q),
    .fill_i        (rspFill),
    .fill_data_i   (i_imemRspData),
    .pop_i         (consume),
    .flush_i       (i_redirectValid),
    .head_o        (head),
    .used_o        (used),
    .outstanding_o (outstanding)
  );

  // Fetch PC advance and stale-response drop accounting.
  always_comb begin
    fetchPc_d = fetchPc_q;
    dropCnt_d = dropCnt_q;
    if (i_redirectValid) begin
      fetchPc_d = alignPc(i_redirectPc);
      dropCnt_d = dropCnt_q + DW'(outstanding)
                  - DW'(i_imemRspValid);
    end else begin
      if (reqFire) begin
        fetchPc_d = fetchPc_q + PC_STEP;
      end
      if (i_imemRspValid && (dropCnt_q != '0)) begin
        dropCnt_d = dropCnt_q - DW'(1);
      end
    end
  end

  // Fetch PC and drop counter registers.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      fetchPc_q <= alignPc(RESET_PC);
      dropCnt_q <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // A response with nothing in flight breaks the memory protocol.
  always_ff @(posedge i_clk) begin
    if (i_arstn && i_imemRspValid) begin
      assert ((dropCnt_q != '0) || (outstanding != '0))
        else $error("imem response with nothing outstanding");
    end
  end

endmodule
